// File: rtl/dram_cmd_scheduler_pkg.sv
// Shared types for the DRAM command scheduler: request struct, command enum,
// DDR4 address-map field positions and default timing values.
package dram_cmd_scheduler_pkg;

  typedef struct packed {
    logic [1:0]  op;               // 0 read, 1 write, 2 ifetch, 3 drop
    logic [32:0] addr;
    logic [31:0] CPU_clock_count;
  } parser_out_struct;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } dram_cmd_e;

  localparam int ADDR_W    = 33;
  localparam int ROW_W     = 15;
  localparam int COL_W     = 11;
  localparam int BANK_W    = 2;
  localparam int BG_W      = 2;
  localparam int ROW_LSB   = 18;
  localparam int COLH_LSB  = 10;
  localparam int COLH_W    = 8;
  localparam int COLL_LSB  = 3;
  localparam int COLL_W    = 3;
  localparam int BANK_LSB  = 8;
  localparam int BG_LSB    = 6;
  localparam int IDX_W     = BG_W + BANK_W;

  localparam int DEF_TRCD   = 24;
  localparam int DEF_TRP    = 24;
  localparam int DEF_TCL    = 24;
  localparam int DEF_TCWL   = 20;
  localparam int DEF_TBURST = 4;

  typedef struct packed {
    logic [BG_W-1:0]   bg;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } dram_addr_t;

  typedef enum logic [1:0] {
    LK_CLOSED = 2'd0,
    LK_HIT    = 2'd1,
    LK_MISS   = 2'd2
  } bank_lookup_e;

endpackage

// File: rtl/dram_cmd_scheduler_if.sv
// Request-queue / command-trace bundle; master is the queue side, slave the scheduler.
interface dram_cmd_scheduler_if;
  import dram_cmd_scheduler_pkg::*;

  logic              req_valid;
  parser_out_struct  req;
  logic              req_ready;
  logic              cmd_valid;
  dram_cmd_e         cmd_type;
  logic [BG_W-1:0]   cmd_bg;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic              req_done;

  modport master (
    output req_valid, req,
    input  req_ready, cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col, req_done
  );

  modport slave (
    input  req_valid, req,
    output req_ready, cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col, req_done
  );

endinterface

// File: rtl/dram_cmd_scheduler_bank_tracker.sv
// dram_bank_tracker: open-row table, one valid+row entry per {bg, bank}.
// Lookup is combinational; set/clear are registered, asynchronous active-low reset.
module dram_bank_tracker
  import dram_cmd_scheduler_pkg::*;
#(
  parameter int NUM_BANKS = 16
) (
  input  logic              CPU_clock,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  lk_idx,
  input  logic [ROW_W-1:0]  lk_row,
  output bank_lookup_e      lk_res,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic [ROW_W-1:0]  set_row,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx
);

  logic [NUM_BANKS-1:0]            vld;
  logic [NUM_BANKS-1:0][ROW_W-1:0] row;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    always_ff @(posedge CPU_clock or negedge rst_n) begin
      if (!rst_n) begin
        vld[b] <= 1'b0;
        row[b] <= '0;
      end else if (set_en && set_idx == IDX_W'(b)) begin
        vld[b] <= 1'b1;
        row[b] <= set_row;
      end else if (clr_en && clr_idx == IDX_W'(b)) begin
        vld[b] <= 1'b0;
      end
    end
  end

  always_comb begin
    lk_res = LK_CLOSED;
    if (vld[lk_idx]) lk_res = (row[lk_idx] == lk_row) ? LK_HIT : LK_MISS;
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Serial DDR4 command scheduler: one request in flight, ACT/RD/WR/PRE on DRAM ticks (CPU_clock/2).
// OPEN_PAGE_EN defined: open-page with row hits; undefined: closed-page (PRE after every burst).
module dram_cmd_scheduler
  import dram_cmd_scheduler_pkg::*;
#(
  parameter int TRCD   = DEF_TRCD,
  parameter int TRP    = DEF_TRP,
  parameter int TCL    = DEF_TCL,
  parameter int TCWL   = DEF_TCWL,
  parameter int TBURST = DEF_TBURST
) (
  input  logic                 CPU_clock,
  input  logic                 rst_n,
  dram_cmd_scheduler_if.slave  bus
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] LD_RDATA = CNT_W'(TCL + TBURST - 1);
  localparam logic [CNT_W-1:0] LD_WDATA = CNT_W'(TCWL + TBURST - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_PRE       = 3'd2;
  localparam logic [2:0] S_WAIT_RP   = 3'd3;
  localparam logic [2:0] S_ACT       = 3'd4;
  localparam logic [2:0] S_WAIT_RCD  = 3'd5;
  localparam logic [2:0] S_RW        = 3'd6;
  localparam logic [2:0] S_WAIT_DATA = 3'd7;

  typedef enum logic [1:0] {GO_NONE, GO_PRE, GO_ACT, GO_RW} go_e;

  logic [2:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             tick;
  logic             closing, nxt_closing;
  logic             cur_wr;
  logic             done;
  logic             xfer;
  go_e              go;
  dram_addr_t       cur, req_dec;
  bank_lookup_e     lk_res;
  logic             unused_req_bits;

  assign unused_req_bits = ^{bus.req.CPU_clock_count, bus.req.addr[2:0]};

  assign req_dec.row  = bus.req.addr[ROW_LSB +: ROW_W];
  assign req_dec.col  = {bus.req.addr[COLH_LSB +: COLH_W], bus.req.addr[COLL_LSB +: COLL_W]};
  assign req_dec.bank = bus.req.addr[BANK_LSB +: BANK_W];
  assign req_dec.bg   = bus.req.addr[BG_LSB +: BG_W];

  // X on valid or op must never look like a transfer
  assign xfer = (state == S_IDLE) && (bus.req_valid === 1'b1) && !$isunknown(bus.req.op);
  assign bus.req_ready = (state == S_IDLE);

  dram_bank_tracker u_tracker (
    .CPU_clock (CPU_clock),
    .rst_n     (rst_n),
    .lk_idx    ({cur.bg, cur.bank}),
    .lk_row    (cur.row),
    .lk_res    (lk_res),
    .set_en    (go == GO_ACT),
    .set_idx   ({cur.bg, cur.bank}),
    .set_row   (cur.row),
    .clr_en    (go == GO_PRE),
    .clr_idx   ({cur.bg, cur.bank})
  );

  // Wait states issue the follow-on command on the same tick the counter reads 0,
  // which keeps command spacing at exactly 2*T CPU cycles.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_closing = closing;
    go          = GO_NONE;
    done        = 1'b0;
    case (state)
      S_IDLE: if (xfer) begin
        if (bus.req.op == 2'd3) done = 1'b1;
        else                    nxt_state = S_DECODE;
      end
      S_DECODE: case (lk_res)
        LK_HIT:  nxt_state = S_RW;
        LK_MISS: nxt_state = S_PRE;
        default: nxt_state = S_ACT;
      endcase
      S_PRE: if (tick) go = GO_PRE;
      S_ACT: if (tick) go = GO_ACT;
      S_RW:  if (tick) go = GO_RW;
      S_WAIT_RP: if (tick) begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else if (closing) begin
          done        = 1'b1;
          nxt_closing = 1'b0;
          nxt_state   = S_IDLE;
        end else go = GO_ACT;
      end
      S_WAIT_RCD: if (tick) begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else           go = GO_RW;
      end
      S_WAIT_DATA: if (tick) begin
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else begin
`ifdef OPEN_PAGE_EN
          done      = 1'b1;
          nxt_state = S_IDLE;
`else
          go          = GO_PRE;
          nxt_closing = 1'b1;
`endif
        end
      end
      default: nxt_state = S_IDLE;
    endcase
    case (go)
      GO_PRE: begin nxt_state = S_WAIT_RP;   nxt_cnt = LD_RP;  end
      GO_ACT: begin nxt_state = S_WAIT_RCD;  nxt_cnt = LD_RCD; end
      GO_RW:  begin nxt_state = S_WAIT_DATA; nxt_cnt = cur_wr ? LD_WDATA : LD_RDATA; end
      default: ;
    endcase
  end

  always_ff @(posedge CPU_clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tick          <= 1'b0;
      closing       <= 1'b0;
      cur           <= '0;
      cur_wr        <= 1'b0;
      bus.req_done  <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_type  <= CMD_NOP;
      bus.cmd_bg    <= '0;
      bus.cmd_bank  <= '0;
      bus.cmd_row   <= '0;
      bus.cmd_col   <= '0;
    end else begin
      tick    <= ~tick;
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      closing <= nxt_closing;
      if (xfer) begin
        cur    <= req_dec;
        cur_wr <= (bus.req.op == 2'd1);
      end
      bus.req_done  <= done;
      bus.cmd_valid <= (go != GO_NONE);
      bus.cmd_type  <= CMD_NOP;
      bus.cmd_bg    <= '0;
      bus.cmd_bank  <= '0;
      bus.cmd_row   <= '0;
      bus.cmd_col   <= '0;
      case (go)
        GO_PRE: begin
          bus.cmd_type <= CMD_PRE;
          bus.cmd_bg   <= cur.bg;
          bus.cmd_bank <= cur.bank;
        end
        GO_ACT: begin
          bus.cmd_type <= CMD_ACT;
          bus.cmd_bg   <= cur.bg;
          bus.cmd_bank <= cur.bank;
          bus.cmd_row  <= cur.row;
        end
        GO_RW: begin
          bus.cmd_type <= cur_wr ? CMD_WR : CMD_RD;
          bus.cmd_bg   <= cur.bg;
          bus.cmd_bank <= cur.bank;
          bus.cmd_row  <= cur.row;
          bus.cmd_col  <= cur.col;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: command order, fields and CPU-cycle spacing.
module tb_dram_cmd_scheduler;
  import dram_cmd_scheduler_pkg::*;

  logic CPU_clock = 1'b0;
  logic rst_n     = 1'b0;
  always #5 CPU_clock = ~CPU_clock;

  dram_cmd_scheduler_if bus();
  dram_cmd_scheduler dut (.CPU_clock(CPU_clock), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          cyc;
    logic        done;
    dram_cmd_e   t;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [10:0] col;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge CPU_clock) cyc <= cyc + 1;

  // Every command and every req_done, stamped with the posedge count that produced it
  always @(negedge CPU_clock) begin
    if (bus.cmd_valid === 1'b1)
      evq.push_back('{cyc, 1'b0, bus.cmd_type, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col});
    if (bus.req_done === 1'b1)
      evq.push_back('{cyc, 1'b1, CMD_NOP, 2'd0, 2'd0, 15'd0, 11'd0});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_ev(output ev_t e);
    int n = 0;
    while (evq.size() == 0 && n < 300) begin
      @(negedge CPU_clock); #1;
      n++;
    end
    if (evq.size() == 0) begin
      chk("ev_timeout", 64'(evq.size()), 64'(1));
      e = '{-1000, 1'b0, CMD_NOP, 2'd0, 2'd0, 15'd0, 11'd0};
    end else e = evq.pop_front();
  endtask

  task automatic exp_cmd(input string tag, input dram_cmd_e t, input logic [1:0] bg,
                         input logic [1:0] bank, input logic [14:0] row, input logic [10:0] col,
                         input int ref_c, input int dmin, input int dmax, output int c);
    ev_t e;
    next_ev(e);
    chk({tag, ".type"}, 64'({e.done, e.t}), 64'({1'b0, t}));
    chk({tag, ".fields"}, 64'({e.bg, e.bank, e.row, e.col}), 64'({bg, bank, row, col}));
    if (dmin == dmax) chk({tag, ".delay"}, 64'(e.cyc - ref_c), 64'(dmin));
    else chk({tag, ".delay_in_range"}, 64'((e.cyc - ref_c >= dmin) && (e.cyc - ref_c <= dmax)), 64'(1));
    c = e.cyc;
  endtask

  task automatic exp_done(input string tag, input int ref_c, input int dly, output int c);
    ev_t e;
    next_ev(e);
    chk({tag, ".is_done"}, 64'(e.done), 64'(1));
    chk({tag, ".delay"}, 64'(e.cyc - ref_c), 64'(dly));
    c = e.cyc;
  endtask

  // Tail of a request after its RD/WR: direct done (open page) or PRE then done
  task automatic tail(input string tag, input logic [1:0] bg, input logic [1:0] bank,
                      input int c_rw, input int data_dly);
    int cp, cd;
`ifdef OPEN_PAGE_EN
    exp_done({tag, ".done"}, c_rw, data_dly, cd);
`else
    exp_cmd({tag, ".pre"}, CMD_PRE, bg, bank, 15'd0, 11'd0, c_rw, data_dly, data_dly, cp);
    exp_done({tag, ".done"}, cp, 48, cd);
`endif
  endtask

  task automatic send(input logic [1:0] op, input logic [32:0] addr, input bit hold, output int xc);
    int n = 0;
    bus.req       = '{op: op, addr: addr, CPU_clock_count: 32'(cyc)};
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 300) begin
      @(negedge CPU_clock); #1;
      n++;
    end
    chk("send.ready", 64'(bus.req_ready), 64'(1));
    xc = cyc + 1;
    @(negedge CPU_clock); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    int xc, ca, cr, cp, cd;
    bus.req_valid = 1'b0;
    bus.req       = '0;
    repeat (3) @(negedge CPU_clock);
    #1;
    chk("rst.req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst.cmd_valid", 64'(bus.cmd_valid), 64'(0));
    chk("rst.req_done", 64'(bus.req_done), 64'(0));
    chk("rst.cmd_type", 64'(bus.cmd_type), 64'(CMD_NOP));
    chk("rst.fields", 64'({bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}), 64'(0));
    rst_n = 1'b1;
    @(negedge CPU_clock); #1;

    // 1: cold read of address 0
    send(2'd0, 33'h0_0000_0000, 1'b0, xc);
    exp_cmd("t1.act", CMD_ACT, 2'd0, 2'd0, 15'd0, 11'd0, xc, 2, 3, ca);
    chk("t1.busy", 64'(bus.req_ready), 64'(0));
    exp_cmd("t1.rd", CMD_RD, 2'd0, 2'd0, 15'd0, 11'd0, ca, 48, 48, cr);
    tail("t1", 2'd0, 2'd0, cr, 56);

    // 2: same row, column 1
    send(2'd0, 33'h0_0000_0008, 1'b0, xc);
`ifdef OPEN_PAGE_EN
    exp_cmd("t2.rd", CMD_RD, 2'd0, 2'd0, 15'd0, 11'd1, xc, 2, 3, cr);
`else
    exp_cmd("t2.act", CMD_ACT, 2'd0, 2'd0, 15'd0, 11'd0, xc, 2, 3, ca);
    exp_cmd("t2.rd", CMD_RD, 2'd0, 2'd0, 15'd0, 11'd1, ca, 48, 48, cr);
`endif
    tail("t2", 2'd0, 2'd0, cr, 56);

    // 3: row 1 in bank 0
    send(2'd0, 33'h0_0004_0000, 1'b0, xc);
`ifdef OPEN_PAGE_EN
    exp_cmd("t3.pre", CMD_PRE, 2'd0, 2'd0, 15'd0, 11'd0, xc, 2, 3, cp);
    exp_cmd("t3.act", CMD_ACT, 2'd0, 2'd0, 15'd1, 11'd0, cp, 48, 48, ca);
`else
    exp_cmd("t3.act", CMD_ACT, 2'd0, 2'd0, 15'd1, 11'd0, xc, 2, 3, ca);
`endif
    exp_cmd("t3.rd", CMD_RD, 2'd0, 2'd0, 15'd1, 11'd0, ca, 48, 48, cr);
    tail("t3", 2'd0, 2'd0, cr, 56);

    // 4: write to bg1/bank1
    send(2'd1, 33'h0_0000_0140, 1'b0, xc);
    exp_cmd("t4.act", CMD_ACT, 2'd1, 2'd1, 15'd0, 11'd0, xc, 2, 3, ca);
    exp_cmd("t4.wr", CMD_WR, 2'd1, 2'd1, 15'd0, 11'd0, ca, 48, 48, cr);
    tail("t4", 2'd1, 2'd1, cr, 48);

    // 5: reset while waiting tRCD, then the same bank again
    send(2'd0, 33'h0_0000_0280, 1'b0, xc);
    exp_cmd("t5.act", CMD_ACT, 2'd2, 2'd2, 15'd0, 11'd0, xc, 2, 3, ca);
    repeat (10) @(negedge CPU_clock);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5.rst.req_ready", 64'(bus.req_ready), 64'(1));
    chk("t5.rst.cmd_valid", 64'(bus.cmd_valid), 64'(0));
    chk("t5.rst.req_done", 64'(bus.req_done), 64'(0));
    chk("t5.rst.cmd_type", 64'(bus.cmd_type), 64'(CMD_NOP));
    repeat (4) @(negedge CPU_clock);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge CPU_clock);
    #1;
    chk("t5.no_events", 64'(evq.size()), 64'(0));
    send(2'd0, 33'h0_0000_0280, 1'b0, xc);
    exp_cmd("t5.react", CMD_ACT, 2'd2, 2'd2, 15'd0, 11'd0, xc, 2, 3, ca);
    exp_cmd("t5.rd", CMD_RD, 2'd2, 2'd2, 15'd0, 11'd0, ca, 48, 48, cr);
    tail("t5", 2'd2, 2'd2, cr, 56);

    // 6: valid held high across ops 2, 3, 2
    send(2'd2, 33'h0_0000_0000, 1'b1, xc);
    bus.req = '{op: 2'd3, addr: 33'h0_0000_0000, CPU_clock_count: 32'(cyc)};
    exp_cmd("t6a.act", CMD_ACT, 2'd0, 2'd0, 15'd0, 11'd0, xc, 2, 3, ca);
    chk("t6a.busy_act", 64'(bus.req_ready), 64'(0));
    exp_cmd("t6a.rd", CMD_RD, 2'd0, 2'd0, 15'd0, 11'd0, ca, 48, 48, cr);
    chk("t6a.busy_rd", 64'(bus.req_ready), 64'(0));
`ifdef OPEN_PAGE_EN
    exp_done("t6a.done", cr, 56, cd);
`else
    exp_cmd("t6a.pre", CMD_PRE, 2'd0, 2'd0, 15'd0, 11'd0, cr, 56, 56, cp);
    chk("t6a.busy_pre", 64'(bus.req_ready), 64'(0));
    exp_done("t6a.done", cp, 48, cd);
`endif
    exp_done("t6b.drop", cd, 1, cd);
    bus.req = '{op: 2'd2, addr: 33'h0_0000_0000, CPU_clock_count: 32'(cyc)};
    xc = cyc + 1;
    @(negedge CPU_clock); #1;
    bus.req_valid = 1'b0;
`ifdef OPEN_PAGE_EN
    exp_cmd("t6c.rd", CMD_RD, 2'd0, 2'd0, 15'd0, 11'd0, xc, 2, 3, cr);
`else
    exp_cmd("t6c.act", CMD_ACT, 2'd0, 2'd0, 15'd0, 11'd0, xc, 2, 3, ca);
    exp_cmd("t6c.rd", CMD_RD, 2'd0, 2'd0, 15'd0, 11'd0, ca, 48, 48, cr);
`endif
    chk("t6c.busy", 64'(bus.req_ready), 64'(0));
    tail("t6c", 2'd0, 2'd0, cr, 56);

    repeat (6) @(negedge CPU_clock);
    #1;
    chk("end.no_events", 64'(evq.size()), 64'(0));
    chk("end.req_ready", 64'(bus.req_ready), 64'(1));
    chk("end.idle_fields", 64'({bus.cmd_type, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
